// File: rtl/cbus_pkg.sv
// Cache-bus request/response bundles shared by the caches,
// the arbiter and the memory bridge.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [8:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of the per-master cbus ports and the merged bridge port.
// The arbiter takes the slave side, caches and bridge the master side.
interface cbus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import cbus_pkg::*;

  cbus_req_t  ireqs  [NUM_MASTERS];
  cbus_resp_t iresps [NUM_MASTERS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq
  );

endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin merge of N cache-bus masters onto one bridge port.
// A grant is held for the whole burst, up to the ready beat with last.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input logic           clk,
  input logic           reset,
  cbus_arbiter_if.slave bus
);

  localparam int SEL_WIDTH = $clog2(NUM_MASTERS);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] win;
  logic [SEL_WIDTH-1:0] sel_next;
  logic                 any_valid;
  logic                 done;

  // Scan downward so the lowest offset from ptr is the last to win.
  always_comb begin
    int j;
    win       = ptr;
    any_valid = 1'b0;
    j         = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_MASTERS;
      if (bus.ireqs[j].valid) begin
        win       = SEL_WIDTH'(j);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    if (int'(sel) == NUM_MASTERS - 1) begin
      sel_next = '0;
    end else begin
      sel_next = sel + SEL_WIDTH'(1);
    end
  end

  assign done = bus.oresp.ready && bus.oresp.last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            sel   <= win;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            ptr   <= sel_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state/sel, so reset clears them at once.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.iresps[i] = '0;
    end
    if (state == BUSY) begin
      bus.oreq        = bus.ireqs[sel];
      bus.iresps[sel] = bus.oresp;
    end
  end

  a_no_ready_idle: assert property (
    @(posedge clk) disable iff (reset)
    (state == IDLE) |-> !bus.oresp.ready
  );

  a_sel_range: assert property (
    @(posedge clk) disable iff (reset)
    int'(sel) < NUM_MASTERS
  );

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_chk
    a_ready_sel: assert property (
      @(posedge clk) disable iff (reset)
      bus.iresps[g].ready |-> (state == BUSY && int'(sel) == g)
    );
  end

endmodule
